// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, 16x oversampling FSM and a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits, plus the parity_err_o output.
module uart_rx #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int FifoDepth      = 4
) (
  input  logic                           clk_sys_i,
  input  logic                           rst_sys_ni,
  input  logic                           uart_rx_i,
  output logic [7:0]                     rx_data_o,
  output logic                           rx_valid_o,
  input  logic                           rx_ready_i,
  output logic                           frame_err_o,
  output logic                           overrun_o,
`ifdef UART_RX_PARITY_EN
  output logic                           parity_err_o,
`endif
  output logic                           busy_o,
  output logic [$clog2(FifoDepth+1)-1:0] fifo_level_o
);

  localparam int DivRaw  = ClockFrequency / (BaudRate * 16);
  localparam int Divider = (DivRaw < 1) ? 1 : DivRaw;
  localparam int DivW    = (Divider > 1) ? $clog2(Divider) : 1;
  localparam int PtrW    = $clog2(FifoDepth);
  localparam int LvlW    = $clog2(FifoDepth + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e state_q, state_d;

  // Synchronizer and edge detector idle high so reset never looks like a start bit.
  logic sync_q, rx_s, rx_prev_q;
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync_q    <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop capture the previous stage's old value.
      sync_q    <= uart_rx_i;
      rx_s      <= sync_q;
      rx_prev_q <= rx_s;
    end
  end

  logic fall;
  assign fall = rx_prev_q & ~rx_s;

  // Oversampling tick; held at zero in IDLE so every frame starts phase-aligned.
  logic [DivW-1:0] div_cnt_q;
  logic            tick;
  assign tick = (div_cnt_q == DivW'(Divider - 1));

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni)                     div_cnt_q <= '0;
    else if (state_q == S_IDLE || tick)  div_cnt_q <= '0;
    else                                 div_cnt_q <= div_cnt_q + 1'b1;
  end

  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       frame_err_d, overrun_d, push, pop, full, bit_done;
`ifdef UART_RX_PARITY_EN
  logic       parity_bad_q, parity_bad_d, parity_err_d;
`endif

  assign bit_done = tick && (tick_cnt_q == ((state_q == S_START) ? 4'd7 : 4'd15));

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif
    if (state_q == S_IDLE)  tick_cnt_d = '0;
    else if (tick)          tick_cnt_d = bit_done ? 4'd0 : tick_cnt_q + 4'd1;

    case (state_q)
      S_IDLE: if (fall) state_d = S_START;
      S_START: if (bit_done) begin
        bit_idx_d = '0;
        state_d   = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (bit_done) begin
        shift_d   = {rx_s, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
        if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (bit_done) begin
        parity_bad_d = rx_s ^ (^shift_q);
        state_d      = S_STOP;
      end
`endif
      S_STOP: if (bit_done) begin
        state_d = S_IDLE;
        if (!rx_s)                frame_err_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
        else if (parity_bad_q)    parity_err_d = 1'b1;
`endif
        else if (full && !pop)    overrun_d    = 1'b1;
        else                      push         = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_o <= frame_err_d;
      overrun_o   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_o <= parity_err_d;
`endif
    end
  end

  assign busy_o = (state_q != S_IDLE);

  // Receive FIFO: pointers wrap naturally because FifoDepth is a power of two.
  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] count_q;

  assign rx_valid_o   = (count_q != '0);
  assign full         = (count_q == LvlW'(FifoDepth));
  assign pop          = rx_valid_o & rx_ready_i;
  assign fifo_level_o = count_q;
  assign rx_data_o    = rx_valid_o ? mem_q[rd_ptr_q] : 8'h00;

  // NOTE: storage has no reset; occupancy is tracked by count_q and the output is gated by rx_valid_o.
  always_ff @(posedge clk_sys_i) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + LvlW'(1);
        2'b01:   count_q <= count_q - LvlW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic against a queue-based model.
// Build with UART_RX_PARITY_EN defined to also cover the parity variant.
module tb_uart_rx;

  localparam int Depth = 4;
`ifdef UART_RX_PARITY_EN
  localparam int  FrameBits = 11;
  localparam bit  ParEn     = 1'b1;
`else
  localparam int  FrameBits = 10;
  localparam bit  ParEn     = 1'b0;
`endif
  // Divider is 1, so a bit lasts 16 clocks; the stop bit is sampled during this clock offset of the frame.
  localparam int StopSample = FrameBits * 16 - 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
  logic [2:0] level;
  logic       parity_err;

  always #5 clk = ~clk;

  uart_rx #(
    .ClockFrequency(1_600_000),
    .BaudRate      (100_000),
    .FifoDepth     (Depth)
  ) dut (
    .clk_sys_i   (clk),
    .rst_sys_ni  (rst_n),
    .uart_rx_i   (line),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (ready),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(parity_err),
`endif
    .busy_o      (busy),
    .fifo_level_o(level)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  int pass_cnt = 0, total_cnt = 0, fail_cnt = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic [7:0] model_q[$];

  // Counts high cycles of each pulse output, so a clean pulse adds exactly one.
  always @(negedge clk) begin
    if (frame_err  === 1'b1) fe_cnt++;
    if (overrun    === 1'b1) ov_cnt++;
    if (parity_err === 1'b1) pe_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_err"}, 32'(fe_cnt), 32'(exp_fe));
    check({tag, "_overrun"},   32'(ov_cnt), 32'(exp_ov));
    check({tag, "_parity"},    32'(pe_cnt), 32'(exp_pe));
    check({tag, "_level"},     32'(level),  32'(model_q.size()));
  endtask

  // Drives one frame starting at a negedge; optionally pops for exactly the stop-sample clock.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit par_ok,
                            input bit pop_at_stop);
    logic [FrameBits-1:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_ok, (^data) ^ ~par_ok, data, 1'b0};
`else
    bits = {stop_ok, data, 1'b0};
`endif
    for (int c = 0; c < FrameBits * 16; c++) begin
      line = bits[c / 16];
      if (pop_at_stop && c == StopSample) begin
        check("pop_at_stop_data", 32'(rx_data), 32'(model_q[0]));
        ready = 1'b1;
        void'(model_q.pop_front());
      end else begin
        ready = 1'b0;
      end
      @(negedge clk);
    end
    ready = 1'b0;
    line  = 1'b1;
    if (!stop_ok)                      exp_fe++;
    else if (ParEn && !par_ok)         exp_pe++;
    else if (model_q.size() >= Depth)  exp_ov++;
    else                               model_q.push_back(data);
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check(tag, 32'(rx_data), 32'(model_q[0]));
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    void'(model_q.pop_front());
  endtask

  initial begin
    logic [7:0] b;
    bit         s_ok, p_ok;
    int         waited;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_flags", 32'({frame_err, overrun, parity_err}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte, then pop
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check_flags("a5");
    pop_check("a5_data");
    check("a5_after_pop_valid", 32'(rx_valid), 32'd0);
    check("a5_after_pop_level", 32'(level), 32'd0);

    // Short low glitch must be rejected
    line = 1'b0;
    repeat (5) @(negedge clk);
    line = 1'b1;
    waited = 0;
    while (busy && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("glitch_busy_low", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check_flags("glitch");

    // Framing error, then recovery
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check_flags("frame_err");
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    check_flags("after_ferr");
    pop_check("after_ferr_data");

    // Held break: exactly one framing error
    line = 1'b0;
    repeat (400) @(negedge clk);
    line = 1'b1;
    repeat (30) @(negedge clk);
    exp_fe++;
    check_flags("break");

    // Overrun on the fifth byte
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0);
    check_flags("overrun");
    for (int i = 0; i < 4; i++) pop_check("overrun_pop");
    check("overrun_drained", 32'(level), 32'd0);

    // Full FIFO with pop in the stop-sample clock: push accepted
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0);
    send_frame(8'h05, 1'b1, 1'b1, 1'b1);
    check_flags("full_pop");
    for (int i = 0; i < 4; i++) pop_check("full_pop_order");

    // Asynchronous reset in the middle of a data phase
    line = 1'b0;
    repeat (16) @(negedge clk);
    line = 1'b1;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_outs", 32'({rx_valid, frame_err, overrun, parity_err}), 32'd0);
    check("midrst_data_level", 32'({rx_data, level}), 32'd0);
    model_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h42, 1'b1, 1'b1, 1'b0);
    check_flags("post_rst");
    pop_check("post_rst_data");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check_flags("parity_bad");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check_flags("parity_good");
    pop_check("parity_good_data");
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check_flags("ferr_over_parity");
`endif

    // Randomized traffic against the queue model
    for (int i = 0; i < 10; i++) begin
      b    = 8'($urandom);
      s_ok = ($urandom_range(0, 4) != 0);
      p_ok = ($urandom_range(0, 4) != 0);
      send_frame(b, s_ok, p_ok, 1'b0);
      check_flags("rand");
      if (model_q.size() > 0 && $urandom_range(0, 1) == 1) pop_check("rand_pop");
    end
    while (model_q.size() > 0) pop_check("rand_drain");
    check("final_valid", 32'(rx_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
